// File: rtl/pwm_pkg.sv
// Shared constants and state encoding for the PWM output stage.
package pwm_pkg;
  localparam int         PWM_CNT_W = 8;
  localparam logic [7:0] DUTY_FULL = 8'hFF;
  localparam int         NUM_OUT   = 16;

  typedef enum logic {IDLE, RUN} state_e;
endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaler, 8-bit period counter and the duty shadow register.
// The shadow only reloads while stopped or at the wrap, keeping pulses glitch-free.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = 13,
  parameter int PRESC_W = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic [PWM_CNT_W-1:0] duty_in,
  output logic [PWM_CNT_W-1:0] cnt,
  output logic [PWM_CNT_W-1:0] duty_shadow,
  output logic                 period_start
);

  localparam logic [PRESC_W-1:0]   PRESC_MAX = PRESC_W'(CLK_DIV - 1);
  localparam logic [PWM_CNT_W-1:0] CNT_MAX   = {PWM_CNT_W{1'b1}};

  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [PWM_CNT_W-1:0] cnt_q, cnt_d;
  logic [PWM_CNT_W-1:0] duty_q, duty_d;
  logic                 ps_q, ps_d;
  logic                 tick;

  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    duty_d  = duty_q;
    ps_d    = 1'b0;
    tick    = 1'b0;
    if (!run) begin
      presc_d = '0;
      cnt_d   = '0;
      duty_d  = duty_in;
    end else begin
      tick    = (presc_q == PRESC_MAX);
      presc_d = tick ? '0 : presc_q + PRESC_W'(1);
      if (tick) begin
        cnt_d = cnt_q + PWM_CNT_W'(1);
        // Period boundary: latch the new duty and flag the restart.
        if (cnt_q == CNT_MAX) begin
          duty_d = duty_in;
          ps_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
      duty_q  <= '0;
      ps_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      ps_q    <= ps_d;
    end
  end

  assign cnt          = cnt_q;
  assign duty_shadow  = duty_q;
  assign period_start = ps_q;

endmodule

// File: rtl/pwm_output_stage.sv
// 16-pin output stage: each pin off, static high, or modulated by a shared duty.
// The timebase only runs while at least one enabled pin is in PWM mode.
module pwm_output_stage
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = 13,
  parameter int PRESC_W = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         en_reg_out_7_0,
  input  logic [7:0]         en_reg_out_15_8,
  input  logic [7:0]         en_reg_pwm_7_0,
  input  logic [7:0]         en_reg_pwm_15_8,
  input  logic [7:0]         pwm_duty_cycle,
  output logic [NUM_OUT-1:0] out,
  output logic               period_start
);

  logic [NUM_OUT-1:0]   en, pe;
  logic [NUM_OUT-1:0]   out_q, out_d;
  logic                 pwm_any, run, pwm_level;
  logic [PWM_CNT_W-1:0] cnt, duty_shadow;
  state_e               state_q, state_d;

  assign en      = {en_reg_out_15_8, en_reg_out_7_0};
  assign pe      = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign pwm_any = |(en & pe);

  always_comb begin
    state_d = state_q;
    run     = 1'b0;
    case (state_q)
      IDLE: if (pwm_any) state_d = RUN;
      RUN: begin
        // Hold the timebase in clear on the way out so a restart begins at cnt=0.
        if (!pwm_any) state_d = IDLE;
        else          run     = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  pwm_timebase #(
    .CLK_DIV (CLK_DIV),
    .PRESC_W (PRESC_W)
  ) u_timebase (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .duty_in      (pwm_duty_cycle),
    .cnt          (cnt),
    .duty_shadow  (duty_shadow),
    .period_start (period_start)
  );

  assign pwm_level = (duty_shadow == DUTY_FULL) | (cnt < duty_shadow);
  assign out_d     = en & (~pe | {NUM_OUT{pwm_level}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= '0;
    else        out_q <= out_d;
  end

  assign out = out_q;

endmodule

// File: tb/tb_pwm_output_stage.sv
// Directed bench for pwm_output_stage with CLK_DIV=2 and CLK_DIV=13 instances.
module tb_pwm_output_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi, duty;
  logic [15:0] out2, out13, out_mon;
  logic        ps2, ps13, ps_mon;
  logic        use13;
  int          bit_sel;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  pwm_output_stage #(.CLK_DIV(2), .PRESC_W(12)) dut (
    .clk (clk), .rst_n (rst_n),
    .en_reg_out_7_0 (eo_lo), .en_reg_out_15_8 (eo_hi),
    .en_reg_pwm_7_0 (ep_lo), .en_reg_pwm_15_8 (ep_hi),
    .pwm_duty_cycle (duty), .out (out2), .period_start (ps2)
  );

  pwm_output_stage #(.CLK_DIV(13), .PRESC_W(12)) dut13 (
    .clk (clk), .rst_n (rst_n),
    .en_reg_out_7_0 (eo_lo), .en_reg_out_15_8 (eo_hi),
    .en_reg_pwm_7_0 (ep_lo), .en_reg_pwm_15_8 (ep_hi),
    .pwm_duty_cycle (duty), .out (out13), .period_start (ps13)
  );

  assign out_mon = use13 ? out13 : out2;
  assign ps_mon  = use13 ? ps13 : ps2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_io(input logic [15:0] en, input logic [15:0] pe);
    {eo_hi, eo_lo} = en;
    {ep_hi, ep_lo} = pe;
  endtask

  task automatic go_idle();
    set_io(16'h0000, 16'h0000);
    step(3);
  endtask

  // Number of consecutive samples (including the current one) at level lvl.
  task automatic run_len(input logic lvl, input int maxc, output int n);
    n = 0;
    while (out_mon[bit_sel] == lvl && n < maxc) begin
      step(1);
      n++;
    end
  endtask

  task automatic wait_ps(input int maxc, output int n);
    n = 0;
    while (!ps_mon && n < maxc) begin
      step(1);
      n++;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, h, cnt_ps, cnt_hi;
    use13 = 1'b0;
    bit_sel = 0;
    rst_n = 1'b0;
    set_io(16'hFFFF, 16'h0000);
    duty = 8'h55;
    step(3);
    chk("rst_out", {16'h0, out2}, 32'h0);
    chk("rst_ps", {31'h0, ps2}, 32'h0);
    chk("rst_out13", {16'h0, out13}, 32'h0);
    rst_n = 1'b1;
    step(1);
    chk("rel_static", {16'h0, out2}, 32'hFFFF);
    go_idle();

    // Static outputs and one-cycle latency
    duty = 8'h40;
    set_io(16'h00FF, 16'h0000);
    #1;
    chk("static_pre", {16'h0, out2}, 32'h0);
    step(1);
    chk("static_on", {16'h0, out2}, 32'h00FF);
    set_io(16'h0000, 16'h0000);
    step(1);
    chk("static_off", {16'h0, out2}, 32'h0);

    // PWM select without enable stays low
    duty = 8'hFF;
    set_io(16'h0000, 16'hFFFF);
    step(2);
    chk("pe_no_en", {16'h0, out2}, 32'h0);
    go_idle();

    // 50% duty
    duty = 8'h80;
    step(2);
    set_io(16'h0001, 16'h0001);
    wait_ps(2000, n);
    step(1);
    run_len(1'b1, 2000, n);
    chk("d50_high", n, 256);
    run_len(1'b0, 2000, n);
    chk("d50_low", n, 256);
    wait_ps(2000, n);
    step(1);
    wait_ps(2000, n);
    chk("d50_ps_int", n + 1, 512);
    step(1);
    chk("ps_one_cycle", {31'h0, ps2}, 32'h0);

    // Asynchronous reset mid-period, then restart from IDLE
    step(100);
    chk("pre_rst_high", {31'h0, out2[0]}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_rst", {16'h0, out2}, 32'h0);
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("restart_first", {31'h0, out2[0]}, 32'h0);
    step(1);
    run_len(1'b1, 2000, n);
    chk("restart_high", n, 256);
    go_idle();

    // Duty 0x00 over three periods
    duty = 8'h00;
    step(2);
    set_io(16'h0001, 16'h0001);
    cnt_ps = 0;
    cnt_hi = 0;
    for (int i = 0; i < 1600; i++) begin
      step(1);
      if (out2[0]) cnt_hi++;
      if (ps2) cnt_ps++;
    end
    chk("d00_high", cnt_hi, 0);
    chk("d00_ps", cnt_ps, 3);
    go_idle();

    // Duty 0xFF over three periods
    duty = 8'hFF;
    step(2);
    set_io(16'h0001, 16'h0001);
    cnt_hi = 0;
    for (int i = 0; i < 1600; i++) begin
      step(1);
      if (!out2[0]) cnt_hi++;
    end
    chk("dff_low", cnt_hi, 0);
    go_idle();

    // Duty change mid-period takes effect only after the wrap
    duty = 8'h40;
    step(2);
    set_io(16'h0001, 16'h0001);
    wait_ps(2000, n);
    step(1);
    h = 0;
    for (int i = 0; i < 64; i++) begin
      if (out2[0]) h++;
      step(1);
    end
    duty = 8'hC0;
    run_len(1'b1, 2000, n);
    chk("glitch_cur", h + n, 128);
    wait_ps(2000, n);
    step(1);
    run_len(1'b1, 2000, n);
    chk("glitch_next", n, 384);
    go_idle();

    // Carrier at CLK_DIV=13
    use13 = 1'b1;
    bit_sel = 15;
    duty = 8'h19;
    step(2);
    set_io(16'h8000, 16'h8000);
    wait_ps(5000, n);
    step(1);
    run_len(1'b1, 5000, n);
    chk("c13_high", n, 325);
    run_len(1'b0, 5000, n);
    chk("c13_low", n, 3003);
    wait_ps(5000, n);
    step(1);
    wait_ps(5000, n);
    chk("c13_period", n + 1, 3328);
    go_idle();

    // Mixed static and modulated pins
    use13 = 1'b0;
    bit_sel = 4;
    set_io(16'hFFFF, 16'h00F0);
    wait_ps(2000, n);
    step(1);
    chk("mixed_high", {16'h0, out2}, 32'hFFFF);
    step(60);
    chk("mixed_low", {16'h0, out2}, 32'hFF0F);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
